// File: rtl/sirius_fetch_pkg.sv
// Shared fetch-path definitions used by the instruction fetch queue.
//   fetch_entry_t : one queued instruction word plus its PC
//   INST_BYTES    : PC increment between adjacent fetched words
//   FETCH_WIDTH   : instructions delivered by the i$ per cycle
package sirius_fetch_pkg;
    localparam int INST_BYTES  = 4;
    localparam int FETCH_WIDTH = 2;

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc;
    } fetch_entry_t;
endpackage

// File: rtl/inst_fetch_queue_mem.sv
// Entry storage for the instruction fetch queue: DEPTH x fetch_entry_t
// register array, two write ports, two asynchronous read ports.
// Storage is deliberately not reset; validity is tracked by the owner.
//   clk             : clock
//   we0/waddr0/wdata0, we1/waddr1/wdata1 : write ports (distinct addresses
//                     whenever both are enabled)
//   raddr0/rdata0, raddr1/rdata1         : combinational read ports
module inst_fetch_queue_mem
    import sirius_fetch_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int PTR_W = $clog2(DEPTH)
) (
    input  logic               clk,
    input  logic               we0,
    input  logic [PTR_W-1:0]   waddr0,
    input  fetch_entry_t       wdata0,
    input  logic               we1,
    input  logic [PTR_W-1:0]   waddr1,
    input  fetch_entry_t       wdata1,
    input  logic [PTR_W-1:0]   raddr0,
    output fetch_entry_t       rdata0,
    input  logic [PTR_W-1:0]   raddr1,
    output fetch_entry_t       rdata1
);
    fetch_entry_t mem_q [DEPTH];
    fetch_entry_t mem_d [DEPTH];

    always_comb begin
        mem_d = mem_q;
        if (we0) mem_d[waddr0] = wdata0;
        if (we1) mem_d[waddr1] = wdata1;
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign rdata0 = mem_q[raddr0];
    assign rdata1 = mem_q[raddr1];
endmodule

// File: rtl/inst_fetch_queue.sv
// Instruction fetch queue between the i$ hit path and decode.
// Accepts 0/1/2 instructions per cycle, presents the two oldest to decode,
// decode pops 0/1/2 per cycle. Flush (redirect) empties the queue.
// Optional macro INST_FETCH_QUEUE_BYPASS_EN: when the queue is empty an
// accepted push is forwarded to out_* in the same cycle.
//   clk, rst              : clock, synchronous active-high reset
//   flush                 : discard all contents (beats push/pop, loses to rst)
//   in_pc/in_inst1/in_inst2/in_valid1/in_valid2 : fetch group from i$
//   in_ready              : >= 2 free entries (pre-pop occupancy)
//   out_inst1/out_pc1/out_valid1 : oldest entry
//   out_inst2/out_pc2/out_valid2 : second-oldest entry
//   pop1, pop2            : decode consumption (pop2 needs pop1)
//   count                 : occupancy 0..DEPTH
module inst_fetch_queue
    import sirius_fetch_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic [31:0]                in_pc,
    input  logic [31:0]                in_inst1,
    input  logic [31:0]                in_inst2,
    input  logic                       in_valid1,
    input  logic                       in_valid2,
    output logic                       in_ready,
    output logic [31:0]                out_inst1,
    output logic [31:0]                out_pc1,
    output logic                       out_valid1,
    output logic [31:0]                out_inst2,
    output logic [31:0]                out_pc2,
    output logic                       out_valid2,
    input  logic                       pop1,
    input  logic                       pop2,
    output logic [$clog2(DEPTH):0]     count
);
    localparam int PTR_W = $clog2(DEPTH);

    logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d;
    logic [PTR_W:0]   count_q, count_d;
    logic [1:0]       n_push, n_pop_req, n_pop, n_wr, skip, pop_cnt;
    logic             push_acc, bypass;
    logic             we0, we1;
    fetch_entry_t     ent0, ent1, wd0, rd0, rd1;

    always_comb begin
        n_push    = {1'b0, in_valid1} + {1'b0, in_valid1 & in_valid2};
        n_pop_req = {1'b0, pop1} + {1'b0, pop1 & pop2};
        in_ready  = (count_q <= (PTR_W+1)'(DEPTH - 2));
        push_acc  = in_ready & in_valid1 & ~flush & ~rst;
        ent0      = '{inst: in_inst1, pc: in_pc};
        ent1      = '{inst: in_inst2, pc: in_pc + 32'(INST_BYTES)};
`ifdef INST_FETCH_QUEUE_BYPASS_EN
        bypass    = push_acc & (count_q == '0);
`else
        bypass    = 1'b0;
`endif
        // Pops are limited to what is visible: stored entries, or the
        // forwarded push when bypassing an empty queue.
        n_pop = n_pop_req;
        if (bypass) begin
            if (n_pop_req > n_push) n_pop = n_push;
        end else if ((PTR_W+1)'(n_pop_req) > count_q) begin
            n_pop = count_q[1:0];
        end
        // Bypassed pops consume inputs directly and never touch storage.
        skip    = bypass ? n_pop : 2'd0;
        pop_cnt = bypass ? 2'd0 : n_pop;
        n_wr    = push_acc ? (n_push - skip) : 2'd0;

        we0 = (n_wr != 2'd0);
        we1 = (n_wr == 2'd2);
        wd0 = (skip != 2'd0) ? ent1 : ent0;

        head_d  = head_q + PTR_W'(pop_cnt);
        tail_d  = tail_q + PTR_W'(n_wr);
        count_d = count_q + (PTR_W+1)'(n_wr) - (PTR_W+1)'(pop_cnt);
        if (flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    inst_fetch_queue_mem #(.DEPTH(DEPTH), .PTR_W(PTR_W)) u_mem (
        .clk    (clk),
        .we0    (we0),
        .waddr0 (tail_q),
        .wdata0 (wd0),
        .we1    (we1),
        .waddr1 (tail_q + PTR_W'(1)),
        .wdata1 (ent1),
        .raddr0 (head_q),
        .rdata0 (rd0),
        .raddr1 (head_q + PTR_W'(1)),
        .rdata1 (rd1)
    );

    always_comb begin
        out_valid1 = (count_q != '0);
        out_valid2 = (count_q >= (PTR_W+1)'(2));
        out_inst1  = out_valid1 ? rd0.inst : 32'd0;
        out_pc1    = out_valid1 ? rd0.pc   : 32'd0;
        out_inst2  = out_valid2 ? rd1.inst : 32'd0;
        out_pc2    = out_valid2 ? rd1.pc   : 32'd0;
`ifdef INST_FETCH_QUEUE_BYPASS_EN
        if (bypass) begin
            out_valid1 = 1'b1;
            out_valid2 = in_valid2;
            out_inst1  = ent0.inst;
            out_pc1    = ent0.pc;
            out_inst2  = in_valid2 ? ent1.inst : 32'd0;
            out_pc2    = in_valid2 ? ent1.pc   : 32'd0;
        end
`endif
    end

    assign count = count_q;
endmodule
